// File: rtl/adc9826_cfg_seq.sv
// adc9826_cfg_seq: table-driven register sequencer for the AD9826 serial-config engine.
// Reads a header and N entries from parameter RAM, writes each entry into
// adc9826_cfg, kicks the serial transfer and waits for its completion.
// Optional build macro ADC9826_CFG_SEQ_CHECKSUM_EN: XOR of entry data[7:0]
// must equal header[15:8] before the transfer is kicked.
module adc9826_cfg_seq #(
    parameter logic [7:0]  BASE_ADDR   = 8'h00,
    parameter int unsigned MAX_REGS    = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_in,
    output logic        ram_rd_o,
    output logic [7:0]  ram_addr_o,
    input  logic [31:0] ram_din,
    output logic        cfg_wr_o,
    output logic [2:0]  cfg_addr_o,
    output logic [8:0]  cfg_data_o,
    output logic        cfg_start_o,
    input  logic        cfg_done_in,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o
);

    localparam int unsigned IDX_W     = 4;
    localparam int unsigned CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [15:0] MAGIC     = 16'hAD98;
    localparam logic [1:0]  ERR_MAGIC = 2'd1;
    localparam logic [1:0]  ERR_COUNT = 2'd2;
    localparam logic [1:0]  ERR_TMO   = 2'd3;

    typedef enum logic [3:0] {
        IDLE, HDR_RD, HDR_CHK, ENT_RD, ENT_CAP, ENT_WR, KICK, WAIT_DONE, FIN, ERR
    } state_t;

    state_t           state, next_state;
    logic [IDX_W-1:0] idx_q, idx_nxt;
    logic [IDX_W-1:0] n_q, n_nxt;
    logic [CNT_W-1:0] tmo_cnt;
    logic             done_q;
    logic             done_rise;
    logic             idx_last;
    logic [IDX_W-1:0] hdr_n;
    logic             ram_rd_nxt, cfg_wr_nxt, cfg_start_nxt, busy_nxt, done_nxt, err_nxt;
    logic [7:0]       ram_addr_nxt;
    logic [1:0]       err_code_nxt;

`ifdef ADC9826_CFG_SEQ_CHECKSUM_EN
    logic [7:0]       csum_q;
    logic [7:0]       hdr_csum_q;
`else
    logic             unused_din;
    assign unused_din = ^ram_din[15:9];
`endif

    assign hdr_n     = ram_din[3:0];
    assign done_rise = cfg_done_in & ~done_q;
    assign idx_last  = (IDX_W'(idx_q + IDX_W'(1)) == n_q);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    // Next-state decode and next values of the registered outputs
    always_comb begin
        next_state    = state;
        idx_nxt       = idx_q;
        n_nxt         = n_q;
        err_code_nxt  = err_code_o;
        err_nxt       = err_o;
        ram_addr_nxt  = ram_addr_o;
        case (state)
            IDLE: begin
                if (start_in) begin
                    next_state   = HDR_RD;
                    err_nxt      = 1'b0;
                    err_code_nxt = 2'd0;
                end
            end
            HDR_RD: next_state = HDR_CHK;
            HDR_CHK: begin
                if (ram_din[31:16] != MAGIC) begin
                    next_state   = ERR;
                    err_code_nxt = ERR_MAGIC;
                end else if (hdr_n == '0 || 32'(hdr_n) > MAX_REGS) begin
                    next_state   = ERR;
                    err_code_nxt = ERR_COUNT;
                end else begin
                    next_state = ENT_RD;
                    n_nxt      = hdr_n;
                    idx_nxt    = '0;
                end
            end
            ENT_RD:  next_state = ENT_CAP;
            ENT_CAP: next_state = ENT_WR;
            ENT_WR: begin
                idx_nxt = IDX_W'(idx_q + IDX_W'(1));
                if (idx_last) begin
`ifdef ADC9826_CFG_SEQ_CHECKSUM_EN
                    if (csum_q != hdr_csum_q) begin
                        next_state   = ERR;
                        err_code_nxt = ERR_TMO;
                    end else begin
                        next_state = KICK;
                    end
`else
                    next_state = KICK;
`endif
                end else begin
                    next_state = ENT_RD;
                end
            end
            KICK: next_state = WAIT_DONE;
            WAIT_DONE: begin
                // tmo_cnt lags the kick by two cycles, so this lands ERR exactly TIMEOUT_CYC after cfg_start_o
                if (done_rise) begin
                    next_state = FIN;
                end else if (tmo_cnt == CNT_W'(TIMEOUT_CYC - 2)) begin
                    next_state   = ERR;
                    err_code_nxt = ERR_TMO;
                end
            end
            FIN:     next_state = IDLE;
            ERR:     next_state = IDLE;
            default: next_state = IDLE;
        endcase

        if (next_state == ERR) err_nxt = 1'b1;
        if (next_state == HDR_RD) ram_addr_nxt = BASE_ADDR;
        if (next_state == ENT_RD) ram_addr_nxt = 8'(BASE_ADDR + 8'd1 + 8'(idx_nxt));
        ram_rd_nxt    = (next_state == HDR_RD) || (next_state == ENT_RD);
        cfg_wr_nxt    = (next_state == ENT_WR);
        cfg_start_nxt = (next_state == KICK);
        done_nxt      = (next_state == FIN);
        busy_nxt      = !(next_state inside {IDLE, FIN, ERR});
    end

    // Registered outputs and datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_rd_o    <= 1'b0;
            ram_addr_o  <= '0;
            cfg_wr_o    <= 1'b0;
            cfg_addr_o  <= '0;
            cfg_data_o  <= '0;
            cfg_start_o <= 1'b0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            err_code_o  <= '0;
            idx_q       <= '0;
            n_q         <= '0;
            tmo_cnt     <= '0;
            done_q      <= 1'b0;
`ifdef ADC9826_CFG_SEQ_CHECKSUM_EN
            csum_q      <= '0;
            hdr_csum_q  <= '0;
`endif
        end else begin
            ram_rd_o    <= ram_rd_nxt;
            ram_addr_o  <= ram_addr_nxt;
            cfg_wr_o    <= cfg_wr_nxt;
            cfg_start_o <= cfg_start_nxt;
            busy_o      <= busy_nxt;
            done_o      <= done_nxt;
            err_o       <= err_nxt;
            err_code_o  <= err_code_nxt;
            idx_q       <= idx_nxt;
            n_q         <= n_nxt;
            done_q      <= cfg_done_in;
            if (state == KICK)           tmo_cnt <= '0;
            else if (state == WAIT_DONE) tmo_cnt <= CNT_W'(tmo_cnt + CNT_W'(1));
            if (state == ENT_CAP) begin
                cfg_addr_o <= ram_din[18:16];
                cfg_data_o <= ram_din[8:0];
            end
`ifdef ADC9826_CFG_SEQ_CHECKSUM_EN
            if (state == HDR_CHK) begin
                csum_q     <= '0;
                hdr_csum_q <= ram_din[15:8];
            end else if (state == ENT_CAP) begin
                csum_q <= csum_q ^ ram_din[7:0];
            end
`endif
        end
    end

endmodule

// File: tb/tb_adc9826_cfg_seq.sv
// tb_adc9826_cfg_seq: scoreboard bench for adc9826_cfg_seq with a table-level reference model.
module tb_adc9826_cfg_seq;

    localparam logic [7:0] BASE = 8'hFC;
    localparam int MAXR = 8;
    localparam int TMO  = 300;
    localparam int K_WR = 0, K_START = 1, K_DONE = 2, K_ERR = 3;

    typedef struct {
        int         kind;
        logic [2:0] a;
        logic [8:0] d;
        logic [1:0] code;
        int         gap;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_in = 1'b0;
    logic        cfg_done_in = 1'b0;
    logic [31:0] ram_din = '0;
    logic        ram_rd_o, cfg_wr_o, cfg_start_o, busy_o, done_o, err_o;
    logic [7:0]  ram_addr_o;
    logic [2:0]  cfg_addr_o;
    logic [8:0]  cfg_data_o;
    logic [1:0]  err_code_o;

    logic [31:0] mem  [256];
    logic [31:0] ents [16];
    ev_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc_now = 0;
    int          last_ev_cyc = 0;
    logic        err_prev = 1'b0;
    logic        exp_err;
    logic [1:0]  exp_code;

    adc9826_cfg_seq #(.BASE_ADDR(BASE), .MAX_REGS(MAXR), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start_in(start_in),
        .ram_rd_o(ram_rd_o), .ram_addr_o(ram_addr_o), .ram_din(ram_din),
        .cfg_wr_o(cfg_wr_o), .cfg_addr_o(cfg_addr_o), .cfg_data_o(cfg_data_o),
        .cfg_start_o(cfg_start_o), .cfg_done_in(cfg_done_in),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o)
    );

    always #5 clk = ~clk;

    // Parameter RAM: one-cycle read latency
    always @(posedge clk) if (ram_rd_o) ram_din <= mem[ram_addr_o];

    task automatic cmp(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endtask

    function automatic int outs_vec();
        return int'({ram_rd_o, ram_addr_o, cfg_wr_o, cfg_addr_o, cfg_data_o,
                     cfg_start_o, busy_o, done_o, err_o, err_code_o});
    endfunction

    task automatic push_ev(input int kind, input logic [2:0] a, input logic [8:0] d,
                           input logic [1:0] code, input int gap);
        ev_t e;
        e.kind = kind; e.a = a; e.d = d; e.code = code; e.gap = gap;
        exp_q.push_back(e);
    endtask

    // Reference: expected event list for a table run
    task automatic model(input logic [31:0] hdr, input int dly, input bit pre_high);
        int n;
        logic [7:0] x;
        n = int'(hdr[3:0]);
        exp_err = 1'b1;
        if (hdr[31:16] != 16'hAD98) begin
            push_ev(K_ERR, 3'd0, 9'd0, 2'd1, 0); exp_code = 2'd1; return;
        end
        if (n < 1 || n > MAXR) begin
            push_ev(K_ERR, 3'd0, 9'd0, 2'd2, 0); exp_code = 2'd2; return;
        end
        x = 8'd0;
        for (int i = 0; i < n; i++) begin
            push_ev(K_WR, ents[i][18:16], ents[i][8:0], 2'd0, (i == 0) ? 0 : 3);
            x = x ^ ents[i][7:0];
        end
`ifdef ADC9826_CFG_SEQ_CHECKSUM_EN
        if (x != hdr[15:8]) begin
            push_ev(K_ERR, 3'd0, 9'd0, 2'd3, 1); exp_code = 2'd3; return;
        end
`endif
        push_ev(K_START, 3'd0, 9'd0, 2'd0, 1);
        if (dly == 0) begin
            push_ev(K_ERR, 3'd0, 9'd0, 2'd3, TMO); exp_code = 2'd3;
        end else begin
            push_ev(K_DONE, 3'd0, 9'd0, 2'd0, pre_high ? dly + 4 : dly + 1);
            exp_err = 1'b0; exp_code = 2'd0;
        end
    endtask

    task automatic check_ev(input int kind, input logic [2:0] a, input logic [8:0] d,
                            input logic [1:0] code);
        ev_t e;
        int gap;
        total++;
        gap = cyc_now - last_ev_cyc;
        last_ev_cyc = cyc_now;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d a=%0d d=%h code=%0d, want no event",
                     kind, a, d, code);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || (kind == K_WR && (e.a != a || e.d != d)) ||
            (kind == K_ERR && e.code != code) || (e.gap != 0 && gap != e.gap)) begin
            bad++;
            $display("FAIL event: got kind=%0d a=%0d d=%h code=%0d gap=%0d, want kind=%0d a=%0d d=%h code=%0d gap=%0d",
                     kind, a, d, code, gap, e.kind, e.a, e.d, e.code, e.gap);
        end
    endtask

    // Monitor: compare every presented output event against the scoreboard
    always @(negedge clk) begin
        cyc_now++;
        if (rst_n) begin
            if (cfg_wr_o)          check_ev(K_WR, cfg_addr_o, cfg_data_o, 2'd0);
            if (cfg_start_o)       check_ev(K_START, 3'd0, 9'd0, 2'd0);
            if (done_o)            check_ev(K_DONE, 3'd0, 9'd0, 2'd0);
            if (err_o && !err_prev) check_ev(K_ERR, 3'd0, 9'd0, err_code_o);
        end
        err_prev = err_o;
    end

    // One table run: load RAM, predict, start, answer cfg_start_o with cfg_done_in
    task automatic run(input logic [31:0] hdr, input int dly, input bit pre_high,
                       input int restart_at, input int reset_at);
        int cyc;
        int start_seen;
        bit busy_seen;
        bit finished;
        bit was_reset;
        mem[BASE] = hdr;
        for (int i = 0; i < 16; i++) mem[8'(BASE + 8'(i) + 8'd1)] = ents[i];
        model(hdr, dly, pre_high);
        cfg_done_in = pre_high;
        @(negedge clk);
        start_in = 1'b1;
        cyc = 0; start_seen = -1; busy_seen = 0; finished = 0; was_reset = 0;
        while (cyc < TMO + 200) begin
            @(negedge clk);
            cyc++;
            start_in = (restart_at > 0 && cyc == restart_at);
            if (busy_o && !busy_seen) begin
                busy_seen = 1;
                cmp("err_clear_on_start", int'(err_o), 0);
            end
            if (cfg_start_o && start_seen < 0) start_seen = cyc;
            if (start_seen >= 0 && dly > 0) begin
                if (!pre_high) begin
                    if (cyc == start_seen + dly)          cfg_done_in = 1'b1;
                    else if (cyc == start_seen + dly + 1) cfg_done_in = 1'b0;
                end else begin
                    if (cyc == start_seen + dly)          cfg_done_in = 1'b0;
                    else if (cyc == start_seen + dly + 3) cfg_done_in = 1'b1;
                end
            end
            if (reset_at > 0 && start_seen >= 0 && cyc == start_seen + reset_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                cmp("reset_mid_run_outs", outs_vec(), 0);
                exp_q.delete();
                cfg_done_in = 1'b0;
                rst_n = 1'b1;
                finished = 1; was_reset = 1;
                break;
            end
            if (exp_q.size() == 0 && !busy_o) begin
                finished = 1;
                break;
            end
        end
        start_in = 1'b0;
        if (!finished) begin
            total++; bad++;
            $display("FAIL run_bound: got %0d pending events, want 0", exp_q.size());
            exp_q.delete();
        end else if (!was_reset) begin
            cmp("busy_end", int'(busy_o), 0);
            cmp("err_end", int'(err_o), int'(exp_err));
            cmp("code_end", int'(err_code_o), int'(exp_code));
        end
        cfg_done_in = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'd0;
        for (int i = 0; i < 16; i++) ents[i] = 32'd0;
        repeat (3) @(negedge clk);
        cmp("reset_outs", outs_vec(), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal two-entry table (XOR of data = 0x08 in header[15:8])
        ents[0] = 32'h0000_00C8;
        ents[1] = 32'h0001_00C0;
        run(32'hAD98_0802, 50, 0, 0, 0);
        // Header faults
        run(32'h1234_0002, 5, 0, 0, 0);
        run(32'hAD98_0000, 5, 0, 0, 0);
        run(32'hAD98_0809, 5, 0, 0, 0);
        // Timeout, then a clean run clears the sticky error
        ents[0] = 32'h0003_0155;
        run(32'hAD98_5501, 0, 0, 0, 0);
        ents[0] = 32'h0000_00C8;
        run(32'hAD98_0802, 12, 0, 0, 0);
        // Stale-high done level must not complete the run
        run(32'hAD98_0802, 10, 1, 0, 0);
        // Checksum byte off by one: only matters when the checksum build is active
        run(32'hAD98_0902, 20, 0, 0, 0);
        // Second start mid-table is ignored; 4 entries wrap past address 0xFF
        ents[0] = 32'h0002_01AA; ents[1] = 32'hFFF5_0E11;
        ents[2] = 32'h0007_0133; ents[3] = 32'h0004_0000;
        run({16'hAD98, 8'(8'hAA ^ 8'h11 ^ 8'h33 ^ 8'h00), 8'h04}, 7, 0, 5, 0);
        // Reset during WAIT_DONE, then a fresh run
        ents[0] = 32'h0000_00C8; ents[1] = 32'h0001_00C0;
        run(32'hAD98_0802, 0, 0, 0, 10);
        run(32'hAD98_0802, 3, 0, 0, 0);

        // Randomized tables
        for (int r = 0; r < 40; r++) begin
            int n;
            logic [7:0] x;
            logic [31:0] h;
            int dly;
            bit ph;
            int rs;
            for (int i = 0; i < 16; i++) ents[i] = $urandom;
            n = $urandom_range(1, MAXR);
            if ($urandom_range(0, 9) == 0)
                n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(MAXR + 1, 15);
            x = 8'd0;
            for (int i = 0; i < n; i++) x = x ^ ents[i][7:0];
            if ($urandom_range(0, 4) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
            h = {16'hAD98, x, 4'($urandom), 4'(n)};
            if ($urandom_range(0, 9) == 0) h[31:16] = 16'($urandom);
            dly = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 40);
            ph  = ($urandom_range(0, 4) == 0);
            rs  = 0;
            if (h[31:16] == 16'hAD98 && n >= 2 && n <= MAXR && $urandom_range(0, 3) == 0)
                rs = $urandom_range(2, 3 * n);
            run(h, dly, ph, rs, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/adc9826_cfg_seq.md
Name: adc9826_cfg_seq

Overview:
- Table-driven configuration sequencer for the AD9826 serial-config engine (adc9826_cfg); replaces the hard-coded two-register power-up FSM.
- Fetches a register table from the PS-writable parameter RAM, issues one cfg write per entry, kicks cfg_start, and waits for cfg_done.
- Runs in the sclk domain, between plparam RAM port B and adc9826_cfg.

Parameters:
- BASE_ADDR, 8'h00: RAM word address of the table header.
- MAX_REGS, 8: largest legal entry count.
- TIMEOUT_CYC, 65535: clk cycles allowed between cfg_start_o and cfg_done_in rising edge.

Ports:
- clk  in  1  sclk domain clock.
- rst_n  in  1  asynchronous active-low reset.
- start_in  in  1  single-cycle run request (PS GPIO or auto power-up pulse).
- ram_rd_o  out  1  RAM read strobe.
- ram_addr_o  out  8  RAM word address.
- ram_din  in  32  RAM read data, valid the cycle after ram_rd_o.
- cfg_wr_o  out  1  one-cycle register write into adc9826_cfg.
- cfg_addr_o  out  3  register address.
- cfg_data_o  out  9  register data.
- cfg_start_o  out  1  one-cycle serial-transfer kick.
- cfg_done_in  in  1  done indication from adc9826_cfg, level or pulse.
- busy_o  out  1  high from accepted start until DONE or ERR exit.
- done_o  out  1  one-cycle success pulse.
- err_o  out  1  sticky error flag; cleared by the next accepted start.
- err_code_o  out  2  error cause: 0 none, 1 bad magic, 2 bad count, 3 timeout/checksum.

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- Table format:
  - Header word: [31:16] must be 16'hAD98; [3:0] holds entry count N, legal range 1..MAX_REGS.
  - Entry i sits at BASE_ADDR+1+i: [18:16] addr, [8:0] data. Other bits are ignored.
- States: IDLE, HDR_RD, HDR_CHK, ENT_RD, ENT_CAP, ENT_WR, KICK, WAIT_DONE, FIN, ERR.
- IDLE:
  - start_in=1 → HDR_RD.
  - Clear err_o and err_code_o; set busy_o.
- HDR_RD:
  - ram_rd_o=1, ram_addr_o=BASE_ADDR.
  - → HDR_CHK.
- HDR_CHK (ram_din valid):
  - Magic mismatch → ERR, code 1.
  - N==0 or N>MAX_REGS → ERR, code 2.
  - Otherwise latch N, set i=0 → ENT_RD.
- ENT_RD:
  - ram_rd_o=1, ram_addr_o=BASE_ADDR+1+i, 8-bit wrap.
  - → ENT_CAP.
- ENT_CAP:
  - Register ram_din[18:16] onto cfg_addr_o and ram_din[8:0] onto cfg_data_o.
  - → ENT_WR.
- ENT_WR:
  - cfg_wr_o=1 for exactly this cycle; i++.
  - If i==N → KICK, else → ENT_RD.
  - Cost: 3 cycles per entry; cfg_wr_o is asserted 2 cycles after its ram_rd_o.
- KICK:
  - cfg_start_o=1 for one cycle.
  - Sample cfg_done_in into the edge register so a stale high level is not accepted.
  - Clear the timeout counter.
  - → WAIT_DONE.
- WAIT_DONE:
  - Rising edge of cfg_done_in → FIN.
  - Counter reaches TIMEOUT_CYC → ERR, code 3.
- FIN: done_o=1 for one cycle, busy_o=0 → IDLE.
- ERR: set err_o, busy_o=0 → IDLE. No cfg_start_o is issued from any error path.
- cfg_addr_o and cfg_data_o hold their last value outside ENT_WR.
- start_in while busy_o=1 is ignored and does not queue.
- Reset mid-run aborts immediately; outputs return to their reset values.

Optional Feature:
- Macro ADC9826_CFG_SEQ_CHECKSUM_EN.
- Defined:
  - A running XOR of ram_din[7:0] over all entries is compared at the ENT_WR→KICK transition against header[15:8].
  - Mismatch → ERR, code 3; cfg_start_o is not issued, although entry writes have already occurred.
  - The checksum accumulator is cleared in HDR_CHK.
- Undefined: header[15:8] is ignored and no accumulator logic exists.

Test Plan:
- Header 32'hAD98_0002, entries {0, 0x0C8} and {1, 0x0C0}; start pulse; done pulse 50 cycles after kick → two cfg_wr_o with addr 0/data 0x0C8 then addr 1/data 0x0C0, 3 cycles apart; one cfg_start_o; done_o 1 cycle after the edge; busy_o low; err_o=0.
- Header 32'h1234_0002 → err_o=1, code 1, no cfg_wr_o or cfg_start_o. Header 32'hAD98_0000 or 32'hAD98_0009 → code 2.
- Valid 1-entry table, cfg_done_in never rises → err_o set exactly TIMEOUT_CYC cycles after cfg_start_o, code 3; next start clears err_o.
- cfg_done_in held high before start → no early completion; a low-then-high edge is required for done_o.
- Second start_in mid-table and rst_n low during WAIT_DONE → second start ignored (exactly N writes); after reset all outputs are 0 and a fresh start runs cleanly.
- With ADC9826_CFG_SEQ_CHECKSUM_EN: header 32'hAD98_0802, data 0x0C8/0x0C0 (XOR 0x08) → pass; header[15:8]=0x09 → code 3 and no cfg_start_o.
